// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Program-load stage in front of the non-pipelined MIPS core. It accepts a
// stream of instruction words over a valid/ready handshake and writes them to
// consecutive instruction-memory addresses, keeping the core in reset for the
// whole load. After the last write it holds reset for RESET_HOLD more cycles
// and then releases the core.
//
// Optional feature (compile-time macro INSTR_LOADER_VERIFY_EN):
//   After the last write, every loaded address is read back through the
//   core's combinational read port. The XOR of the read-back words must
//   match the XOR of the loaded words, or the loader enters ERROR. Without
//   the macro, read_instr_in is unused and LOAD goes straight to HOLD.
//
// Ports:
//   clock_in           system clock, rising edge
//   reset_in           asynchronous active-low reset
//   start_in           one-cycle pulse that begins a load
//   base_address_in    first write address, sampled on start
//   word_valid_in      source presents a word
//   word_in            instruction word
//   last_in            marks word_in as the final word
//   word_ready_out     loader accepts a word this cycle (combinational)
//   instrWrite_out     instruction-memory write enable
//   instr_address_out  instruction-memory address
//   instr_out          instruction-memory write data
//   read_instr_in      instruction-memory read data (verify only)
//   cpu_reset_out      1 holds the core in reset
//   busy_out           load or verify in progress
//   done_out           core released and running
//   error_out          overflow or verify mismatch
//   word_count_out     words written in the current/last load
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_STEP   = 4,
  parameter int RESET_HOLD  = 4,
  localparam int CNT_W      = $clog2(DEPTH_WORDS + 1)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_address_in,
  input  logic                  word_valid_in,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  last_in,
  output logic                  word_ready_out,
  output logic                  instrWrite_out,
  output logic [ADDR_WIDTH-1:0] instr_address_out,
  output logic [DATA_WIDTH-1:0] instr_out,
  input  logic [DATA_WIDTH-1:0] read_instr_in,
  output logic                  cpu_reset_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [CNT_W-1:0]      word_count_out
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_INIT = HOLD_W'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH_WORDS);

`ifdef INSTR_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERROR, S_VERIFY
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERROR
  } state_t;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] next_addr;   // address the next accepted word goes to
  logic [ADDR_WIDTH-1:0] base_addr;   // base captured on start
  logic [DATA_WIDTH-1:0] checksum;    // XOR of all words written this load
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  handshake;

  assign word_ready_out = (state == S_LOAD);
  assign handshake      = word_valid_in & word_ready_out;

`ifdef INSTR_LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] ver_addr;    // next address to read back
  logic [CNT_W-1:0]      ver_left;    // read-back addresses still to issue
  logic                  ver_rd;      // read_instr_in belongs to an issued address
  logic [DATA_WIDTH-1:0] ver_sum;
  logic [DATA_WIDTH-1:0] ver_acc;

  // The read port is combinational, so the word for the address issued on the
  // previous edge is present on read_instr_in now.
  assign ver_acc = ver_sum ^ (ver_rd ? read_instr_in : '0);
`else
  logic unused_read_instr;
  assign unused_read_instr = ^read_instr_in;
`endif

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state             <= S_IDLE;
      cpu_reset_out     <= 1'b1;
      instrWrite_out    <= 1'b0;
      instr_address_out <= '0;
      instr_out         <= '0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
      error_out         <= 1'b0;
      word_count_out    <= '0;
      next_addr         <= '0;
      base_addr         <= '0;
      checksum          <= '0;
      hold_cnt          <= '0;
`ifdef INSTR_LOADER_VERIFY_EN
      ver_addr          <= '0;
      ver_left          <= '0;
      ver_rd            <= 1'b0;
      ver_sum           <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse following each accepted word.
      instrWrite_out <= 1'b0;

      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start_in) begin
            state          <= S_LOAD;
            next_addr      <= base_address_in;
            base_addr      <= base_address_in;
            word_count_out <= '0;
            checksum       <= '0;
            cpu_reset_out  <= 1'b1;
            busy_out       <= 1'b1;
            done_out       <= 1'b0;
            error_out      <= 1'b0;
          end
        end

        S_LOAD: begin
          if (handshake) begin
            if (word_count_out == CNT_FULL) begin
              // One word past the capacity: drop it and stop.
              state     <= S_ERROR;
              error_out <= 1'b1;
              busy_out  <= 1'b0;
            end else begin
              instrWrite_out    <= 1'b1;
              instr_address_out <= next_addr;
              instr_out         <= word_in;
              next_addr         <= next_addr + STEP;
              word_count_out    <= word_count_out + CNT_W'(1);
              checksum          <= checksum ^ word_in;
              if (last_in) begin
`ifdef INSTR_LOADER_VERIFY_EN
                state    <= S_VERIFY;
                ver_addr <= base_addr;
                ver_left <= word_count_out + CNT_W'(1);
                ver_rd   <= 1'b0;
                ver_sum  <= '0;
`else
                state    <= S_HOLD;
                hold_cnt <= HOLD_INIT;
`endif
              end
            end
          end
        end

`ifdef INSTR_LOADER_VERIFY_EN
        S_VERIFY: begin
          if (ver_left != '0) begin
            instr_address_out <= ver_addr;
            ver_addr          <= ver_addr + STEP;
            ver_left          <= ver_left - CNT_W'(1);
            ver_rd            <= 1'b1;
            ver_sum           <= ver_acc;
          end else if (ver_acc == checksum) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
          end else begin
            state     <= S_ERROR;
            error_out <= 1'b1;
            busy_out  <= 1'b0;
          end
        end
`endif

        S_HOLD: begin
          // Release lands RESET_HOLD edges after the edge that entered HOLD.
          if (hold_cnt == '0) begin
            state         <= S_RUN;
            cpu_reset_out <= 1'b0;
            done_out      <= 1'b1;
            busy_out      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
